// File: rtl/aibcr3_dcc_interp_ctrl.sv
// DCC interpolator loop controller: votes pd_up over a window, steps a
// 3-bit code and drives the sp/sn thermometer trims; locks on dither.
// Optional macro AIBCR3_DCC_LOCK_TRACK_EN: keep tracking while locked.
// Ports: clk, rstb (async low), dcc_en, cfg_manual, cfg_code[2:0],
//   pd_up -> sp[6:0], sn[6:0], dcc_code[2:0], dcc_busy, dcc_lock.
module aibcr3_dcc_interp_ctrl #(
  parameter int         SETTLE_CYC = 16,
  parameter int         NSAMP      = 8,
  parameter int         LOCK_REV   = 4,
  parameter logic [2:0] INIT_CODE  = 3'd3
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       dcc_en,
  input  logic       cfg_manual,
  input  logic [2:0] cfg_code,
  input  logic       pd_up,
  output logic [6:0] sp,
  output logic [6:0] sn,
  output logic [2:0] dcc_code,
  output logic       dcc_busy,
  output logic       dcc_lock
);

  localparam int SW = $clog2(SETTLE_CYC) + 1;
  localparam int NW = $clog2(NSAMP) + 1;
  localparam int RW = $clog2(LOCK_REV) + 1;

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [NW-1:0] SAMP_LAST   = NW'(NSAMP - 1);
  localparam logic [NW:0]   NSAMP_W1    = (NW+1)'(NSAMP);
  localparam logic [RW-1:0] LOCK_N      = RW'(LOCK_REV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_UPDATE,
    S_LOCKED
  } state_t;

  function automatic logic [6:0] thermo(input logic [2:0] c);
    logic [6:0] t;
    for (int i = 0; i < 7; i++) begin
      t[i] = (c > 3'(i));
    end
    return t;
  endfunction

  state_t        state_q, state_d;
  logic [2:0]    code_q, code_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [NW-1:0] samp_cnt_q, samp_cnt_d;
  logic [NW-1:0] up_cnt_q, up_cnt_d;
  logic [RW-1:0] rev_cnt_q, rev_cnt_d;
  logic          last_dir_q, last_dir_d;
  logic          last_vld_q, last_vld_d;
  logic [6:0]    sp_q, sp_d;
  logic [6:0]    sn_q, sn_d;
  logic          busy_q, busy_d;
  logic          lock_q, lock_d;
`ifdef AIBCR3_DCC_LOCK_TRACK_EN
  logic          trk_samp_q, trk_samp_d;
`endif

  logic [NW-1:0] up_nxt;
  logic [RW-1:0] rev_inc;
  logic          dir;
  logic          sat;
  logic          rev_hit;

  always_comb begin
    up_nxt  = up_cnt_q + NW'(pd_up);
    rev_inc = rev_cnt_q + RW'(1);
    // tie (exactly half) resolves to down
    dir     = ({up_cnt_q, 1'b0} > NSAMP_W1);
    sat     = dir ? (code_q == 3'd7) : (code_q == 3'd0);
    rev_hit = last_vld_q && !sat && (dir != last_dir_q);
  end

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    settle_cnt_d = settle_cnt_q;
    samp_cnt_d   = samp_cnt_q;
    up_cnt_d     = up_cnt_q;
    rev_cnt_d    = rev_cnt_q;
    last_dir_d   = last_dir_q;
    last_vld_d   = last_vld_q;
`ifdef AIBCR3_DCC_LOCK_TRACK_EN
    trk_samp_d   = trk_samp_q;
`endif
    if (cfg_manual) begin
      state_d = S_IDLE;
      code_d  = cfg_code;
    end else if (!dcc_en) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d      = S_SETTLE;
          code_d       = INIT_CODE;
          rev_cnt_d    = '0;
          last_dir_d   = 1'b0;
          last_vld_d   = 1'b0;
          settle_cnt_d = '0;
        end
        S_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d    = S_SAMPLE;
            samp_cnt_d = '0;
            up_cnt_d   = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + SW'(1);
          end
        end
        S_SAMPLE: begin
          up_cnt_d = up_nxt;
          if (samp_cnt_q == SAMP_LAST) begin
            state_d = S_UPDATE;
          end else begin
            samp_cnt_d = samp_cnt_q + NW'(1);
          end
        end
        S_UPDATE: begin
          last_dir_d   = dir;
          last_vld_d   = 1'b1;
          settle_cnt_d = '0;
`ifdef AIBCR3_DCC_LOCK_TRACK_EN
          trk_samp_d   = 1'b0;
`endif
          if (rev_hit && (rev_inc == LOCK_N)) begin
            rev_cnt_d = rev_inc;
            state_d   = S_LOCKED;
          end else begin
            rev_cnt_d = rev_hit ? rev_inc : '0;
            state_d   = S_SETTLE;
            if (!sat) begin
              code_d = dir ? code_q + 3'd1 : code_q - 3'd1;
            end
          end
        end
        S_LOCKED: begin
`ifdef AIBCR3_DCC_LOCK_TRACK_EN
          // background windows; only a unanimous vote moves the code
          if (!trk_samp_q) begin
            if (settle_cnt_q == SETTLE_LAST) begin
              trk_samp_d = 1'b1;
              samp_cnt_d = '0;
              up_cnt_d   = '0;
            end else begin
              settle_cnt_d = settle_cnt_q + SW'(1);
            end
          end else begin
            up_cnt_d = up_nxt;
            if (samp_cnt_q == SAMP_LAST) begin
              trk_samp_d   = 1'b0;
              settle_cnt_d = '0;
              if (up_nxt == NW'(NSAMP) && code_q != 3'd7) begin
                code_d = code_q + 3'd1;
              end else if (up_nxt == '0 && code_q != 3'd0) begin
                code_d = code_q - 3'd1;
              end
            end else begin
              samp_cnt_d = samp_cnt_q + NW'(1);
            end
          end
`else
          state_d = S_LOCKED;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end
    sp_d   = thermo(code_d);
    sn_d   = ~thermo(code_d);
    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE) ||
             (state_d == S_UPDATE);
    lock_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= S_IDLE;
      code_q       <= INIT_CODE;
      settle_cnt_q <= '0;
      samp_cnt_q   <= '0;
      up_cnt_q     <= '0;
      rev_cnt_q    <= '0;
      last_dir_q   <= 1'b0;
      last_vld_q   <= 1'b0;
      sp_q         <= thermo(INIT_CODE);
      sn_q         <= ~thermo(INIT_CODE);
      busy_q       <= 1'b0;
      lock_q       <= 1'b0;
`ifdef AIBCR3_DCC_LOCK_TRACK_EN
      trk_samp_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      settle_cnt_q <= settle_cnt_d;
      samp_cnt_q   <= samp_cnt_d;
      up_cnt_q     <= up_cnt_d;
      rev_cnt_q    <= rev_cnt_d;
      last_dir_q   <= last_dir_d;
      last_vld_q   <= last_vld_d;
      sp_q         <= sp_d;
      sn_q         <= sn_d;
      busy_q       <= busy_d;
      lock_q       <= lock_d;
`ifdef AIBCR3_DCC_LOCK_TRACK_EN
      trk_samp_q   <= trk_samp_d;
`endif
    end
  end

  assign sp       = sp_q;
  assign sn       = sn_q;
  assign dcc_code = code_q;
  assign dcc_busy = busy_q;
  assign dcc_lock = lock_q;

endmodule

// File: tb/tb_aibcr3_dcc_interp_ctrl.sv
// Bench for aibcr3_dcc_interp_ctrl: scoreboard of expected code steps,
// reset, saturation, dither lock, tie vote, manual override and abort.
module tb_aibcr3_dcc_interp_ctrl;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       dcc_en = 1'b0;
  logic       cfg_manual = 1'b0;
  logic [2:0] cfg_code = 3'd0;
  logic       pd_up = 1'b0;
  logic [6:0] sp;
  logic [6:0] sn;
  logic [2:0] dcc_code;
  logic       dcc_busy;
  logic       dcc_lock;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  aibcr3_dcc_interp_ctrl dut (
    .clk        (clk),
    .rstb       (rstb),
    .dcc_en     (dcc_en),
    .cfg_manual (cfg_manual),
    .cfg_code   (cfg_code),
    .pd_up      (pd_up),
    .sp         (sp),
    .sn         (sn),
    .dcc_code   (dcc_code),
    .dcc_busy   (dcc_busy),
    .dcc_lock   (dcc_lock)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_change(input int budget, input bit tog,
                             output int n, output bit ok);
    logic [2:0] prev;
    prev = dcc_code;
    ok = 1'b0;
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (tog) pd_up = ~pd_up;
      if (dcc_code !== prev) begin
        ok = 1'b1;
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    cyc(2);
    total++; if (sp !== 7'b000_0111) begin bad++;
      $display("FAIL rst_sp got=%h exp=07", sp); end
    total++; if (sn !== 7'b111_1000) begin bad++;
      $display("FAIL rst_sn got=%h exp=78", sn); end
    total++; if (dcc_code !== 3'd3) begin bad++;
      $display("FAIL rst_code got=%0d exp=3", dcc_code); end
    total++; if (dcc_busy !== 1'b0) begin bad++;
      $display("FAIL rst_busy got=%b exp=0", dcc_busy); end
    total++; if (dcc_lock !== 1'b0) begin bad++;
      $display("FAIL rst_lock got=%b exp=0", dcc_lock); end
    rstb = 1'b1;
    cyc(1);
  endtask

  task automatic test_monotonic_up();
    int n;
    bit ok;
    int e;
    pd_up = 1'b1;
    dcc_en = 1'b1;
    cyc(1);
    for (int c = 4; c <= 7; c++) exp_q.push_back(c);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_change(40, 1'b0, n, ok);
      total++; if (!ok || dcc_code !== 3'(e)) begin bad++;
        $display("FAIL up_code got=%0d exp=%0d", dcc_code, e); end
      total++; if (n != 25) begin bad++;
        $display("FAIL up_spacing got=%0d exp=25", n); end
    end
    cyc(60);
    total++; if (dcc_code !== 3'd7) begin bad++;
      $display("FAIL sat_code got=%0d exp=7", dcc_code); end
    total++; if (sp !== 7'h7F || sn !== 7'h00) begin bad++;
      $display("FAIL sat_sp got=%h/%h exp=7f/00", sp, sn); end
    total++; if (dcc_lock !== 1'b0) begin bad++;
      $display("FAIL sat_lock got=%b exp=0", dcc_lock); end
  endtask

  task automatic test_async_reset();
    @(posedge clk);
    #2;
    rstb = 1'b0;
    #1;
    total++; if (dcc_code !== 3'd3 || sp !== 7'h07) begin bad++;
      $display("FAIL arst_code got=%0d/%h exp=3/07", dcc_code, sp); end
    total++; if (dcc_busy !== 1'b0) begin bad++;
      $display("FAIL arst_busy got=%b exp=0", dcc_busy); end
    dcc_en = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    cyc(1);
  endtask

  task automatic test_dither_lock();
    int n;
    bit ok;
    int e;
    pd_up = 1'b1;
    dcc_en = 1'b1;
    cyc(1);
    total++; if (dcc_code !== 3'd3 || dcc_busy !== 1'b1) begin bad++;
      $display("FAIL dith_start got=%0d/%b exp=3/1", dcc_code, dcc_busy); end
    exp_q.push_back(4);
    exp_q.push_back(3);
    exp_q.push_back(4);
    exp_q.push_back(3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_change(40, 1'b0, n, ok);
      total++; if (!ok || dcc_code !== 3'(e) || dcc_lock !== 1'b0) begin
        bad++;
        $display("FAIL dith_code got=%0d lock=%b exp=%0d lock=0",
                 dcc_code, dcc_lock, e);
      end
      pd_up = ~pd_up;
    end
    for (int i = 0; i < 40 && dcc_lock !== 1'b1; i++) @(negedge clk);
    total++; if (dcc_lock !== 1'b1) begin bad++;
      $display("FAIL dith_lock got=%b exp=1", dcc_lock); end
    total++; if (dcc_code !== 3'd3 || dcc_busy !== 1'b0) begin bad++;
      $display("FAIL dith_hold got=%0d/%b exp=3/0", dcc_code, dcc_busy); end
    wait_change(60, 1'b1, n, ok);
    total++; if (ok || dcc_code !== 3'd3) begin bad++;
      $display("FAIL lock_frozen got=%0d exp=3", dcc_code); end
`ifdef AIBCR3_DCC_LOCK_TRACK_EN
    pd_up = 1'b1;
    exp_q.push_back(4);
    e = exp_q.pop_front();
    wait_change(60, 1'b0, n, ok);
    total++; if (!ok || dcc_code !== 3'(e) || dcc_lock !== 1'b1) begin
      bad++;
      $display("FAIL trk_step got=%0d lock=%b exp=%0d lock=1",
               dcc_code, dcc_lock, e);
    end
    cyc(16);
    pd_up = 1'b0;
    cyc(1);
    pd_up = 1'b1;
    cyc(20);
    total++; if (dcc_code !== 3'd4 || dcc_lock !== 1'b1) begin bad++;
      $display("FAIL trk_7of8 got=%0d lock=%b exp=4 lock=1",
               dcc_code, dcc_lock);
    end
`endif
    dcc_en = 1'b0;
    cyc(1);
    total++; if (dcc_lock !== 1'b0 || dcc_busy !== 1'b0) begin bad++;
      $display("FAIL unlock got=%b/%b exp=0/0", dcc_lock, dcc_busy); end
`ifdef AIBCR3_DCC_LOCK_TRACK_EN
    total++; if (dcc_code !== 3'd4) begin bad++;
      $display("FAIL unlock_code got=%0d exp=4", dcc_code); end
`else
    total++; if (dcc_code !== 3'd3) begin bad++;
      $display("FAIL unlock_code got=%0d exp=3", dcc_code); end
`endif
    cyc(2);
  endtask

  task automatic test_tie_vote();
    int n;
    bit ok;
    int e;
    pd_up = 1'b0;
    dcc_en = 1'b1;
    cyc(1);
    total++; if (dcc_code !== 3'd3) begin bad++;
      $display("FAIL tie_start got=%0d exp=3", dcc_code); end
    exp_q.push_back(2);
    e = exp_q.pop_front();
    wait_change(40, 1'b1, n, ok);
    total++; if (!ok || dcc_code !== 3'(e)) begin bad++;
      $display("FAIL tie_down got=%0d exp=%0d", dcc_code, e); end
    total++; if (sp !== 7'h03 || sn !== 7'h7C) begin bad++;
      $display("FAIL tie_sp got=%h/%h exp=03/7c", sp, sn); end
    dcc_en = 1'b0;
    cyc(2);
  endtask

  task automatic test_manual();
    pd_up = 1'b1;
    dcc_en = 1'b1;
    cyc(1);
    total++; if (dcc_code !== 3'd3) begin bad++;
      $display("FAIL man_start got=%0d exp=3", dcc_code); end
    cyc(19);
    total++; if (dcc_busy !== 1'b1) begin bad++;
      $display("FAIL man_busy_pre got=%b exp=1", dcc_busy); end
    cfg_manual = 1'b1;
    cfg_code = 3'd6;
    cyc(1);
    total++; if (dcc_busy !== 1'b0 || dcc_lock !== 1'b0) begin bad++;
      $display("FAIL man_busy got=%b/%b exp=0/0", dcc_busy, dcc_lock); end
    total++; if (sp !== 7'h3F || sn !== 7'h40 || dcc_code !== 3'd6) begin
      bad++;
      $display("FAIL man_code got=%h/%h/%0d exp=3f/40/6", sp, sn, dcc_code);
    end
    cfg_manual = 1'b0;
    cyc(1);
    total++; if (dcc_code !== 3'd3 || dcc_busy !== 1'b1) begin bad++;
      $display("FAIL man_rel got=%0d/%b exp=3/1", dcc_code, dcc_busy); end
  endtask

  task automatic test_abort();
    int n;
    bit ok;
    int e;
    exp_q.push_back(4);
    exp_q.push_back(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_change(40, 1'b0, n, ok);
      total++; if (!ok || dcc_code !== 3'(e)) begin bad++;
        $display("FAIL abort_step got=%0d exp=%0d", dcc_code, e); end
    end
    cyc(5);
    dcc_en = 1'b0;
    cyc(1);
    total++; if (dcc_busy !== 1'b0 || dcc_code !== 3'd5) begin bad++;
      $display("FAIL abort got=%b/%0d exp=0/5", dcc_busy, dcc_code); end
    cyc(30);
    total++; if (dcc_code !== 3'd5 || sp !== 7'h1F) begin bad++;
      $display("FAIL abort_hold got=%0d/%h exp=5/1f", dcc_code, sp); end
  endtask

  initial begin
    test_reset();
    test_monotonic_up();
    test_async_reset();
    test_dither_lock();
    test_tie_vote();
    test_manual();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
